// File: rtl/dsp_sequencer.sv
// rtl/dsp_sequencer.sv - sample-locked DSP program counter sequencer with period measurement
module dsp_sequencer #(
  parameter int PC_WIDTH     = 11,
  parameter int PERIOD_WIDTH = 13,
  parameter int LOCK_COUNT   = 4
) (
  input  logic                    dsp_clk,
  input  logic                    reset_n,
  input  logic                    sample_strobe,
  input  logic                    free_run,
  input  logic [PC_WIDTH:0]       prog_len,
  input  logic                    clear_flags,
  output logic [PC_WIDTH-1:0]     pc,
  output logic                    pc_valid,
  output logic                    frame_start,
  output logic                    locked,
  output logic                    overrun,
  output logic [PERIOD_WIDTH-1:0] period_cycles
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [PC_WIDTH-1:0]     pc_nxt;
  logic [PC_WIDTH:0]       len_shadow;
  logic [PC_WIDTH:0]       len_in;
  logic [PC_WIDTH:0]       last_addr;
  logic                    free_run_q;
  logic                    seen_strobe;
  logic [LOCK_W-1:0]       lock_cnt;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic                    period_start;
  logic                    clean_period;
  logic                    short_period;
  logic                    mode_exit;
  logic                    at_last;
  logic                    period_sat;

  // A programmed length of zero runs a one-instruction program.
  assign len_in     = (prog_len == '0) ? {{PC_WIDTH{1'b0}}, 1'b1} : prog_len;
  assign last_addr  = len_shadow - {{PC_WIDTH{1'b0}}, 1'b1};
  assign at_last    = ({1'b0, pc} == last_addr);
  assign period_sat = &period_cnt;
  assign pc_valid   = (state == RUN);
  assign locked     = (lock_cnt == LOCK_W'(LOCK_COUNT));

  // State register.
  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, next pc and period events; free-run entry/exit override strobe sequencing.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    period_start = 1'b0;
    clean_period = 1'b0;
    short_period = 1'b0;
    mode_exit    = 1'b0;
    if (free_run) begin
      state_nxt = RUN;
      if (!free_run_q || at_last) begin
        pc_nxt       = '0;
        period_start = 1'b1;
      end else begin
        pc_nxt = pc + 1'b1;
      end
    end else if (free_run_q) begin
      state_nxt = IDLE;
      pc_nxt    = '0;
      mode_exit = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            state_nxt    = RUN;
            pc_nxt       = '0;
            period_start = 1'b1;
          end
        end
        RUN: begin
          if (sample_strobe) begin
            pc_nxt       = '0;
            period_start = 1'b1;
            clean_period = at_last;
            short_period = !at_last;
          end else if (at_last) begin
            state_nxt = WAIT;
          end else begin
            pc_nxt = pc + 1'b1;
          end
        end
        WAIT: begin
          if (sample_strobe) begin
            state_nxt    = RUN;
            pc_nxt       = '0;
            period_start = 1'b1;
            clean_period = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          pc_nxt    = '0;
        end
      endcase
    end
  end

  // Program counter, frame marker and length shadow captured at each period start.
  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      frame_start <= 1'b0;
      len_shadow  <= {{PC_WIDTH{1'b0}}, 1'b1};
      free_run_q  <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      frame_start <= period_start;
      free_run_q  <= free_run;
      if (period_start) begin
        len_shadow <= len_in;
      end
    end
  end

  // Lock qualification: clean periods count up, any disturbance restarts qualification.
  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt <= '0;
    end else if (free_run || mode_exit || short_period || (period_sat && !sample_strobe)) begin
      lock_cnt <= '0;
    end else if (clean_period && !locked) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Sticky overrun; a new truncation beats a simultaneous clear.
  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (short_period) begin
      overrun <= 1'b1;
    end else if (clear_flags) begin
      overrun <= 1'b0;
    end
  end

  // Strobe-to-strobe period measurement; the first strobe only starts the count.
  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt    <= '0;
      period_cycles <= '0;
      seen_strobe   <= 1'b0;
    end else if (sample_strobe) begin
      period_cnt  <= '0;
      seen_strobe <= 1'b1;
      if (seen_strobe) begin
        period_cycles <= period_sat ? period_cnt : period_cnt + 1'b1;
      end
    end else if (!period_sat) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb/tb_dsp_sequencer.sv - directed self-checking bench for dsp_sequencer
module tb_dsp_sequencer;

  logic        dsp_clk;
  logic        reset_n;
  logic        sample_strobe;
  logic        free_run;
  logic [11:0] prog_len;
  logic        clear_flags;
  logic [10:0] pc;
  logic        pc_valid;
  logic        frame_start;
  logic        locked;
  logic        overrun;
  logic [12:0] period_cycles;

  int errors = 0;
  int checks = 0;

  dsp_sequencer #(
    .PC_WIDTH(11),
    .PERIOD_WIDTH(13),
    .LOCK_COUNT(4)
  ) dut (
    .dsp_clk(dsp_clk),
    .reset_n(reset_n),
    .sample_strobe(sample_strobe),
    .free_run(free_run),
    .prog_len(prog_len),
    .clear_flags(clear_flags),
    .pc(pc),
    .pc_valid(pc_valid),
    .frame_start(frame_start),
    .locked(locked),
    .overrun(overrun),
    .period_cycles(period_cycles)
  );

  initial dsp_clk = 1'b0;
  always #5 dsp_clk = ~dsp_clk;

  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int exp_pc, input bit exp_valid, input bit exp_fs);
    chk({tag, ".pc"}, 32'(pc), exp_pc);
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(exp_valid));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(exp_fs));
  endtask

  initial begin
    sample_strobe = 1'b0;
    free_run      = 1'b0;
    prog_len      = 12'd8;
    clear_flags   = 1'b0;
    reset_n       = 1'b0;
    tick();
    tick();
    chk_seq("reset", 0, 1'b0, 1'b0);
    chk("reset.locked", 32'(locked), 0);
    chk("reset.overrun", 32'(overrun), 0);
    chk("reset.period", 32'(period_cycles), 0);

    reset_n = 1'b1;
    tick();
    tick();
    chk_seq("idle", 0, 1'b0, 1'b0);

    // strobe every 10 cycles, program of 8: 8 fetches then 2 wait cycles
    for (int s = 1; s <= 6; s++) begin
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      chk_seq("a", 0, 1'b1, 1'b1);
      chk("a.locked", 32'(locked), (s >= 5) ? 1 : 0);
      chk("a.period", 32'(period_cycles), (s >= 2) ? 10 : 0);
      chk("a.overrun", 32'(overrun), 0);
      for (int k = 1; k < 10; k++) begin
        tick();
        chk_seq("a", (k < 8) ? k : 7, (k < 8), 1'b0);
      end
    end

    // free run, program of 5, strobes 7 cycles apart still measured
    free_run = 1'b1;
    prog_len = 12'd5;
    tick();
    chk_seq("fr", 0, 1'b1, 1'b1);
    chk("fr.locked", 32'(locked), 0);
    for (int j = 1; j <= 14; j++) begin
      sample_strobe = (j == 3 || j == 10);
      tick();
      sample_strobe = 1'b0;
      chk_seq("fr", j % 5, 1'b1, (j % 5) == 0);
      chk("fr.locked", 32'(locked), 0);
      chk("fr.overrun", 32'(overrun), 0);
      if (j >= 10) chk("fr.period", 32'(period_cycles), 7);
    end

    free_run = 1'b0;
    prog_len = 12'd8;
    tick();
    chk_seq("exit", 0, 1'b0, 1'b0);
    chk("exit.locked", 32'(locked), 0);
    tick();
    tick();
    chk_seq("exit.idle", 0, 1'b0, 1'b0);

    // strobe every 8 cycles: back-to-back exact fits
    for (int s = 1; s <= 6; s++) begin
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      chk_seq("b", 0, 1'b1, 1'b1);
      chk("b.locked", 32'(locked), (s >= 5) ? 1 : 0);
      chk("b.overrun", 32'(overrun), 0);
      if (s >= 2) chk("b.period", 32'(period_cycles), 8);
      for (int k = 1; k < 8; k++) begin
        tick();
        chk_seq("b", k, 1'b1, 1'b0);
      end
    end

    // short period of 6 truncates at pc 5; clear in the same cycle loses
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    chk_seq("c", 0, 1'b1, 1'b1);
    chk("c.locked", 32'(locked), 1);
    chk("c.overrun", 32'(overrun), 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_seq("c", k, 1'b1, 1'b0);
    end
    sample_strobe = 1'b1;
    clear_flags   = 1'b1;
    tick();
    sample_strobe = 1'b0;
    clear_flags   = 1'b0;
    chk_seq("c.short", 0, 1'b1, 1'b1);
    chk("c.short.overrun", 32'(overrun), 1);
    chk("c.short.locked", 32'(locked), 0);
    chk("c.short.period", 32'(period_cycles), 6);
    tick();
    chk_seq("c", 1, 1'b1, 1'b0);
    tick();
    chk_seq("c", 2, 1'b1, 1'b0);
    chk("c.sticky", 32'(overrun), 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk_seq("c", 3, 1'b1, 1'b0);
    chk("c.cleared", 32'(overrun), 0);
    for (int k = 4; k < 8; k++) begin
      tick();
      chk_seq("c", k, 1'b1, 1'b0);
    end

    // length change mid-period applies at the next period start
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    chk_seq("e", 0, 1'b1, 1'b1);
    chk("e.overrun", 32'(overrun), 0);
    chk("e.locked", 32'(locked), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_seq("e", k, 1'b1, 1'b0);
    end
    prog_len = 12'd4;
    for (int k = 4; k < 8; k++) begin
      tick();
      chk_seq("e", k, 1'b1, 1'b0);
    end
    tick();
    chk_seq("e.wait", 7, 1'b0, 1'b0);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    chk_seq("e2", 0, 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_seq("e2", k, 1'b1, 1'b0);
    end
    tick();
    chk_seq("e2.wait", 3, 1'b0, 1'b0);
    prog_len = 12'd8;

    // regain lock, then reset in the middle of a run
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    chk_seq("f", 0, 1'b1, 1'b1);
    chk("f.locked", 32'(locked), 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk_seq("f", k, 1'b1, 1'b0);
    end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    chk_seq("f", 0, 1'b1, 1'b1);
    chk("f.locked", 32'(locked), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_seq("f", k, 1'b1, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    chk_seq("rst", 0, 1'b0, 1'b0);
    chk("rst.locked", 32'(locked), 0);
    chk("rst.overrun", 32'(overrun), 0);
    chk("rst.period", 32'(period_cycles), 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_seq("post", 0, 1'b0, 1'b0);
    end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    chk_seq("post.start", 0, 1'b1, 1'b1);
    chk("post.period", 32'(period_cycles), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
